// File: rtl/tdes_cmd_ctrl.sv
// tdes_cmd_ctrl: command/sequencing controller for the 3DES datapath.
// Ports: host cmd handshake, in/out beat metering, core launch/done, status.
module tdes_cmd_ctrl #(
  parameter int KEY_BEATS  = 24,
  parameter int DATA_BEATS = 8,
  parameter int OUT_BEATS  = 8,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  output logic             cmd_ready,
  input  logic             in_valid,
  output logic             shift_in,
  output logic             key_dir,
  output logic             core_start,
  input  logic             core_done,
  input  logic             out_ready,
  output logic             shift_out,
  output logic [CNT_W-1:0] in_count,
  output logic [CNT_W-1:0] out_count,
  output logic             key_loaded,
  output logic             in_clear,
  output logic             out_clear,
  output logic             cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_KEY, S_LD_DATA, S_RUN, S_UNLOAD
  } state_t;

  localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_BEATS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BEATS - 1);
  localparam logic [CNT_W-1:0] OUT_FULL  = CNT_W'(OUT_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t state, state_nx;
  logic   data_loaded, core_start_q;
  logic   acc, in_last;
  logic   do_key, do_ld, do_start, do_unl, do_clr, do_err;

  // Command decode with legality checks
  always_comb begin
    acc      = cmd_valid & cmd_ready;
    do_key   = 1'b0;
    do_ld    = 1'b0;
    do_start = 1'b0;
    do_unl   = 1'b0;
    do_clr   = 1'b0;
    do_err   = 1'b0;
    if (acc) begin
      case (cmd)
        3'd1, 3'd2: do_key = 1'b1;
        3'd3: begin
          do_ld  = key_loaded;
          do_err = ~key_loaded;
        end
        3'd4: begin
          do_start = key_loaded & data_loaded;
          do_err   = ~(key_loaded & data_loaded);
        end
        3'd5: do_clr = 1'b1;
        3'd6: begin
          do_unl = (out_count != '0);
          do_err = (out_count == '0);
        end
        3'd7: do_err = 1'b1;
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (do_key)   state_nx = S_LD_KEY;
        if (do_ld)    state_nx = S_LD_DATA;
        if (do_start) state_nx = S_RUN;
        if (do_unl)   state_nx = S_UNLOAD;
      end
      S_LD_KEY, S_LD_DATA:
        if (in_last) state_nx = S_IDLE;
      S_RUN:
        if (core_done) state_nx = S_IDLE;
      S_UNLOAD:
        if (shift_out && out_count == CNT_ONE) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs; reset forces all strobes low in the reset cycle
  always_comb begin
    cmd_ready  = (state == S_IDLE) & ~rst;
    shift_in   = in_valid & ~rst &
                 (state == S_LD_KEY || state == S_LD_DATA);
    shift_out  = out_ready & ~rst & (state == S_UNLOAD);
    core_start = core_start_q & ~rst;
    in_last    = shift_in &
                 ((state == S_LD_KEY) ? (in_count == KEY_LAST)
                                      : (in_count == DATA_LAST));
  end

  // Counters and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      key_dir      <= 1'b0;
      key_loaded   <= 1'b0;
      data_loaded  <= 1'b0;
      in_count     <= '0;
      out_count    <= '0;
      cmd_err      <= 1'b0;
      in_clear     <= 1'b0;
      out_clear    <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      in_clear     <= do_clr;
      out_clear    <= do_clr;
      core_start_q <= do_start;
      if (do_err) cmd_err <= 1'b1;
      if (do_clr) begin
        key_dir     <= 1'b0;
        key_loaded  <= 1'b0;
        data_loaded <= 1'b0;
        in_count    <= '0;
        out_count   <= '0;
        cmd_err     <= 1'b0;
      end
      if (do_key) begin
        key_dir     <= cmd[1];
        key_loaded  <= 1'b0;
        data_loaded <= 1'b0;
        in_count    <= '0;
      end
      if (do_ld) in_count <= '0;
      if (shift_in) begin
        if (in_last) begin
          in_count <= '0;
          if (state == S_LD_KEY) key_loaded  <= 1'b1;
          else                   data_loaded <= 1'b1;
        end else begin
          in_count <= in_count + CNT_ONE;
        end
      end
      if (state == S_RUN && core_done) begin
        out_count   <= OUT_FULL;
        data_loaded <= 1'b0;
      end
      if (shift_out) out_count <= out_count - CNT_ONE;
    end
  end

endmodule
